// File: rtl/ex_muldiv.sv
// ex_muldiv: RV32M multiply/divide execute unit.
// Iterative shift-add multiply, restoring divide.
module ex_muldiv #(
  parameter int XLEN     = 32,
  parameter int MUL_ITER = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] op1_i,
  input  logic [XLEN-1:0] op2_i,
  input  logic [4:0]      rd_addr_i,
  input  logic            flush_i,
  output logic            busy_o,
  output logic            hold_flag_o,
  output logic            done_o,
  output logic [4:0]      rd_addr_o,
  output logic [XLEN-1:0] rd_data_o,
  output logic            rd_wen_o
);

  localparam int CW = $clog2(XLEN);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam logic [CW-1:0] CNT_LAST = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] MOST_NEG =
    {1'b1, {(XLEN-1){1'b0}}};

  logic [1:0]        state_q, state_d;
  logic [2:0]        f3_q, f3_d;
  logic [4:0]        rd_q, rd_d;
  logic              neg_q, neg_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [2*XLEN-1:0] mcand_q, mcand_d;
  logic [XLEN-1:0]   mplier_q, mplier_d;

  logic            is_div, s1, s2;
  logic            sign1, sign2, div0, ovf;
  logic [XLEN-1:0] abs1, abs2;
  logic [XLEN:0]   tmp, diff;
  logic            ge;

  // Operand conditioning for the issue edge
  always_comb begin
    is_div = funct3_i[2];
    s1 = is_div ? !funct3_i[0]
                : (funct3_i[1:0] != 2'b11);
    s2 = is_div ? !funct3_i[0] : !funct3_i[1];
    sign1 = s1 & op1_i[XLEN-1];
    sign2 = s2 & op2_i[XLEN-1];
    abs1 = sign1 ? -op1_i : op1_i;
    abs2 = sign2 ? -op2_i : op2_i;
    div0 = is_div && (op2_i == '0);
    ovf = is_div && s2 && (op1_i == MOST_NEG)
       && (op2_i == '1);
  end

  // Restoring divide step on {rem, quo} in acc
  always_comb begin
    tmp  = acc_q[2*XLEN-1:XLEN-1];
    diff = tmp - {1'b0, mcand_q[XLEN-1:0]};
    ge   = !diff[XLEN];
  end

  // FSM and datapath next-state
  always_comb begin
    state_d  = state_q;
    f3_d     = f3_q;
    rd_d     = rd_q;
    neg_d    = neg_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    case (state_q)
      IDLE: begin
        if (start_i && !flush_i) begin
          f3_d  = funct3_i;
          rd_d  = rd_addr_i;
          cnt_d = '0;
          neg_d = (is_div && funct3_i[1]) ? sign1
                : (sign1 ^ sign2);
          if (div0) begin
            acc_d   = {op1_i, {XLEN{1'b1}}};
            neg_d   = 1'b0;
            state_d = DONE;
          end else if (ovf) begin
            acc_d   = {{XLEN{1'b0}}, op1_i};
            neg_d   = 1'b0;
            state_d = DONE;
          end else if (is_div) begin
            acc_d   = {{XLEN{1'b0}}, abs1};
            mcand_d = {{XLEN{1'b0}}, abs2};
            state_d = CALC;
          end else begin
            acc_d    = '0;
            mcand_d  = {{XLEN{1'b0}}, abs1};
            mplier_d = abs2;
            state_d  = CALC;
          end
        end
      end
      CALC: begin
        if (flush_i) begin
          state_d = IDLE;
        end else if (f3_q[2]) begin
          acc_d = {ge ? diff[XLEN-1:0] : tmp[XLEN-1:0],
                   acc_q[XLEN-2:0], ge};
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) state_d = DONE;
        end else if (MUL_ITER == 0) begin
          acc_d   = mcand_q * {{XLEN{1'b0}}, mplier_q};
          state_d = DONE;
        end else begin
          if (mplier_q[0]) acc_d = acc_q + mcand_q;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      f3_q     <= '0;
      rd_q     <= '0;
      neg_q    <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else begin
      state_q  <= state_d;
      f3_q     <= f3_d;
      rd_q     <= rd_d;
      neg_q    <= neg_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
    end
  end

  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   dsel, res;

  // Result select with sign correction, gated by done
  always_comb begin
    prod = neg_q ? -acc_q : acc_q;
    dsel = f3_q[1] ? acc_q[2*XLEN-1:XLEN]
                   : acc_q[XLEN-1:0];
    res  = '0;
    case (f3_q)
      3'b000:  res = prod[XLEN-1:0];
      3'b001,
      3'b010,
      3'b011:  res = prod[2*XLEN-1:XLEN];
      default: res = neg_q ? -dsel : dsel;
    endcase
    busy_o      = (state_q != IDLE);
    hold_flag_o = ((state_q == IDLE) && start_i
                   && !flush_i) || (state_q == CALC);
    done_o      = (state_q == DONE) && !flush_i;
    rd_wen_o    = done_o;
    rd_addr_o   = done_o ? rd_q : 5'd0;
    rd_data_o   = done_o ? res : '0;
  end

endmodule

// File: tb/tb_ex_muldiv.sv
// tb_ex_muldiv: directed vectors for ex_muldiv.
// Covers iterative and single-cycle multiply.
module tb_ex_muldiv;

  logic        clk;
  logic        rst_n;
  logic        start1, start0;
  logic [2:0]  funct3;
  logic [31:0] op1, op2;
  logic [4:0]  rd_addr;
  logic        flush;

  logic        busy1, hold1, done1, wen1;
  logic [4:0]  rda1;
  logic [31:0] rdd1;
  logic        busy0, hold0, done0, wen0;
  logic [4:0]  rda0;
  logic [31:0] rdd0;

  int checks = 0;
  int failures = 0;

  ex_muldiv #(.XLEN(32), .MUL_ITER(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .start_i(start1),
    .funct3_i(funct3), .op1_i(op1), .op2_i(op2),
    .rd_addr_i(rd_addr), .flush_i(flush),
    .busy_o(busy1), .hold_flag_o(hold1),
    .done_o(done1), .rd_addr_o(rda1),
    .rd_data_o(rdd1), .rd_wen_o(wen1)
  );

  ex_muldiv #(.XLEN(32), .MUL_ITER(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start_i(start0),
    .funct3_i(funct3), .op1_i(op1), .op2_i(op2),
    .rd_addr_i(rd_addr), .flush_i(flush),
    .busy_o(busy0), .hold_flag_o(hold0),
    .done_o(done0), .rd_addr_o(rda0),
    .rd_data_o(rdd0), .rd_wen_o(wen0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic run_op(input string tag,
                        input bit use0,
                        input logic [2:0] f3,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input logic [4:0] rd,
                        input logic [31:0] exp,
                        input int exp_lat);
    int lat;
    bit hold_ok;
    bit dn;
    lat = 0;
    hold_ok = 1'b1;
    @(posedge clk); #1;
    funct3 = f3; op1 = a; op2 = b; rd_addr = rd;
    if (use0) start0 = 1'b1; else start1 = 1'b1;
    forever begin
      @(negedge clk);
      dn = use0 ? done0 : done1;
      if (dn || lat >= 200) break;
      if (!(use0 ? hold0 : hold1)) hold_ok = 1'b0;
      lat++;
    end
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_data"}, use0 ? rdd0 : rdd1, exp);
    check({tag, "_rd"}, {27'd0, use0 ? rda0 : rda1},
          {27'd0, rd});
    check({tag, "_wen"}, {31'd0, use0 ? wen0 : wen1},
          32'd1);
    check({tag, "_hold"}, {31'd0, hold_ok}, 32'd1);
    check({tag, "_hold_done"},
          {31'd0, use0 ? hold0 : hold1}, 32'd0);
    @(posedge clk); #1;
    start0 = 1'b0; start1 = 1'b0;
    @(negedge clk);
    check({tag, "_pulse"}, {31'd0, use0 ? done0 : done1},
          32'd0);
    check({tag, "_idle"}, {31'd0, use0 ? busy0 : busy1},
          32'd0);
  endtask

  int pulses;

  initial begin
    rst_n = 1'b0; start1 = 1'b0; start0 = 1'b0;
    flush = 1'b0; funct3 = 3'd0; op1 = '0; op2 = '0;
    rd_addr = 5'd0;
    #12;
    check("rst_busy", {31'd0, busy1}, 32'd0);
    check("rst_done", {31'd0, done1}, 32'd0);
    check("rst_data", rdd1, 32'd0);
    check("rst_rd", {27'd0, rda1}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_op("mul", 0, 3'b000, 32'd7, 32'hFFFF_FFFD, 5'd5,
           32'hFFFF_FFEB, 33);
    run_op("mulhu", 0, 3'b011, 32'hFFFF_FFFF,
           32'hFFFF_FFFF, 5'd0, 32'hFFFF_FFFE, 33);
    run_op("mulh", 0, 3'b001, 32'hFFFF_FFFF,
           32'hFFFF_FFFF, 5'd6, 32'h0000_0000, 33);
    run_op("mulhsu", 0, 3'b010, 32'hFFFF_FFFF,
           32'hFFFF_FFFF, 5'd7, 32'hFFFF_FFFF, 33);
    run_op("div", 0, 3'b100, 32'hFFFF_FFF9, 32'd2, 5'd8,
           32'hFFFF_FFFD, 33);
    run_op("rem", 0, 3'b110, 32'hFFFF_FFF9, 32'd2, 5'd9,
           32'hFFFF_FFFF, 33);
    run_op("divu", 0, 3'b101, 32'd100, 32'd7, 5'd10,
           32'd14, 33);
    run_op("remu", 0, 3'b111, 32'd100, 32'd7, 5'd11,
           32'd2, 33);
    run_op("div0", 0, 3'b100, 32'd5, 32'd0, 5'd12,
           32'hFFFF_FFFF, 1);
    run_op("rem0", 0, 3'b110, 32'd5, 32'd0, 5'd13,
           32'd5, 1);
    run_op("divovf", 0, 3'b100, 32'h8000_0000,
           32'hFFFF_FFFF, 5'd14, 32'h8000_0000, 1);
    run_op("removf", 0, 3'b110, 32'h8000_0000,
           32'hFFFF_FFFF, 5'd15, 32'd0, 1);

    // start together with flush must not issue
    @(posedge clk); #1;
    funct3 = 3'b101; op1 = 32'd9; op2 = 32'd2;
    start1 = 1'b1; flush = 1'b1;
    @(negedge clk);
    check("sf_hold", {31'd0, hold1}, 32'd0);
    @(posedge clk); #1;
    start1 = 1'b0; flush = 1'b0;
    @(negedge clk);
    check("sf_busy", {31'd0, busy1}, 32'd0);

    // abort a DIVU at cycle 10
    @(posedge clk); #1;
    funct3 = 3'b101; op1 = 32'd100; op2 = 32'd7;
    rd_addr = 5'd3; start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(negedge clk);
    check("ab_done", {31'd0, done1}, 32'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    check("ab_busy", {31'd0, busy1}, 32'd0);
    check("ab_hold", {31'd0, hold1}, 32'd0);
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (done1) pulses++;
    end
    check("ab_nopulse", pulses, 32'd0);
    @(posedge clk);
    run_op("ab_rerun", 0, 3'b101, 32'd100, 32'd7,
           5'd4, 32'd14, 33);

    // asynchronous reset in the middle of CALC
    @(posedge clk); #1;
    funct3 = 3'b000; op1 = 32'd3; op2 = 32'd4;
    rd_addr = 5'd2; start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    repeat (14) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("mr_busy", {31'd0, busy1}, 32'd0);
    check("mr_hold", {31'd0, hold1}, 32'd0);
    check("mr_done", {31'd0, done1}, 32'd0);
    check("mr_data", rdd1, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (done1) pulses++;
    end
    check("mr_nopulse", pulses, 32'd0);

    run_op("mul_fast", 1, 3'b000, 32'd3, 32'd4, 5'd1,
           32'd12, 2);
    run_op("mulhu_fast", 1, 3'b011, 32'hFFFF_FFFF,
           32'hFFFF_FFFF, 5'd2, 32'hFFFF_FFFE, 2);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/ex_muldiv.md
Name: ex_muldiv

Overview:
- Parametrised multi-cycle execute unit for the RV32M extension: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
- Sits beside the single-cycle ALU in the EX stage. It is selected when opcode is INST_TYPE_R_M and funct7 = 7'b000_0001.
- Stalls the pipeline through ctrl via hold_flag_o while an operation iterates. Returns a register write-back in the same format as the ALU path.

Parameters:
- XLEN, 32: operand/result width in bits. Must be even and at least 8.
- MUL_ITER, 1: 1 = multiply iterates radix-2 shift-add over XLEN cycles. 0 = multiply completes in one CALC cycle through a combinational 2*XLEN multiplier.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- start_i  in  1  M-extension instruction present in EX this cycle
- funct3_i  in  3  operation select, RISC-V M encoding (000 MUL … 111 REMU)
- op1_i  in  XLEN  rs1 value
- op2_i  in  XLEN  rs2 value
- rd_addr_i  in  5  destination register
- flush_i  in  1  jump_en from ctrl; aborts an in-flight operation
- busy_o  out  1  state is not IDLE
- hold_flag_o  out  1  stall request to ctrl
- done_o  out  1  one-cycle completion pulse
- rd_addr_o  out  5  write-back register address
- rd_data_o  out  XLEN  result
- rd_wen_o  out  1  write-back enable (equals done_o)

Behaviour:
- Reset is asynchronous, active-low. State goes to IDLE. All outputs and internal registers go to 0: rd_addr_o = 5'd0, rd_data_o = 0, rd_wen_o = 0, done_o = 0, busy_o = 0.
- FSM states: IDLE, CALC, DONE.
- IDLE → CALC when start_i = 1 and flush_i = 0. Operands, funct3 and rd_addr are latched on this edge.
- Sign handling on latch:
  - Signed ops take absolute values of their operands. MULHSU treats only op1 as signed.
  - Result sign is recorded: quotient sign = sign1 XOR sign2; remainder sign = sign1.
- CALC, multiply (MUL_ITER = 1):
  - Each cycle, if the multiplier LSB is 1, add the multiplicand into a 2*XLEN accumulator.
  - Shift the multiplicand left and the multiplier right.
  - Counter runs 0 … XLEN-1; CALC → DONE when the counter equals XLEN-1.
- CALC, multiply (MUL_ITER = 0): the full product is registered in one cycle, then CALC → DONE.
- CALC, divide: restoring radix-2, one quotient bit per cycle, XLEN cycles, then → DONE.
- Divide special cases are detected at latch time. The FSM goes IDLE → DONE directly (no CALC); latency is 1 cycle.
  - Divisor = 0: quotient = all ones; remainder = dividend.
  - Signed overflow (op1 = most-negative, op2 = -1): quotient = op1; remainder = 0.
- DONE:
  - Asserts done_o = rd_wen_o = 1 for exactly one cycle.
  - rd_addr_o = latched rd_addr.
  - rd_data_o = low XLEN bits of the product (MUL), high XLEN bits (MULH, MULHSU, MULHU), quotient or remainder, with the sign correction applied.
  - DONE → IDLE unconditionally. start_i is ignored in DONE, so the held instruction is not restarted.
- rd_addr_o and rd_data_o are 0 whenever done_o = 0.
- hold_flag_o = (state == IDLE and start_i and !flush_i) or state == CALC. It is combinational, so the stall begins in the issue cycle. It is deasserted in DONE, so the pipeline advances on the DONE edge.
- Latency, start to done_o:
  - Iterative multiply or normal divide: XLEN+1 cycles.
  - MUL_ITER = 0 multiply: 2 cycles.
  - Divide special case: 1 cycle.
- flush_i in CALC or DONE: next state is IDLE, with no done_o and no write-back. flush_i has priority over completion in the same cycle.
- flush_i together with start_i in IDLE: the operation is not started.
- Reset mid-operation: immediate return to IDLE. No partial write-back.
- rd_addr = 0 is still written back (done_o = 1, rd_addr_o = 0); the register file ignores x0 writes.
- Invalid funct3 does not exist: all 8 encodings are defined.

Test Plan:
- MUL: op1 = 32'd7, op2 = 32'hFFFF_FFFD (-3), rd = 5 → done_o at cycle 33, rd_data_o = 32'hFFFF_FFEB, rd_addr_o = 5, hold_flag_o high cycles 0 to 32.
- MULHU: 32'hFFFF_FFFF × 32'hFFFF_FFFF → rd_data_o = 32'hFFFF_FFFE. MULH with the same operands → 32'h0000_0000. MULHSU → 32'hFFFF_FFFF.
- DIV/REM: -7 / 2 → DIV = 32'hFFFF_FFFD (-3), REM = 32'hFFFF_FFFF (-1). DIVU 100 / 7 → 14; REMU → 2.
- Special cases: DIV 5 / 0 → 32'hFFFF_FFFF at 1-cycle latency. REM 5 / 0 → 5. DIV 32'h8000_0000 / -1 → 32'h8000_0000; REM → 0.
- Abort: start DIVU, assert flush_i at cycle 10 → state IDLE next cycle, no done_o pulse, hold_flag_o low. A new start two cycles later completes correctly.
- Reset mid-CALC: deassert rst_n at cycle 15 → all outputs 0 asynchronously. After release with start_i held low: no done_o. Rerun with MUL_ITER = 0: MUL 3 × 4 → 12 in 2 cycles.
